// File: rtl/neorv32_wb_bridge_if.sv
// Signal bundle between the NEORV32 CPU ports, the bridge and the Wishbone core bus.
// The bridge uses the slave modport; the driving side (CPU + memory model) uses master.
interface neorv32_wb_bridge_if;
    logic        ibus_stb_i;
    logic [31:0] ibus_addr_i;
    logic [31:0] ibus_rsp_data_o;
    logic        ibus_rsp_ack_o;
    logic        ibus_rsp_err_o;

    logic        dbus_stb_i;
    logic        dbus_rw_i;
    logic [31:0] dbus_addr_i;
    logic [3:0]  dbus_ben_i;
    logic [31:0] dbus_data_i;
    logic [31:0] dbus_rsp_data_o;
    logic        dbus_rsp_ack_o;
    logic        dbus_rsp_err_o;

    logic        core_cyc;
    logic        core_stb;
    logic        core_we;
    logic [3:0]  core_wstrb;
    logic [31:0] core_addr;
    logic [31:0] core_data_out;
    logic [31:0] core_data_in;
    logic        core_ack;

    modport slave (
        input  ibus_stb_i, ibus_addr_i,
        output ibus_rsp_data_o, ibus_rsp_ack_o, ibus_rsp_err_o,
        input  dbus_stb_i, dbus_rw_i, dbus_addr_i, dbus_ben_i, dbus_data_i,
        output dbus_rsp_data_o, dbus_rsp_ack_o, dbus_rsp_err_o,
        output core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out,
        input  core_data_in, core_ack
    );

    modport master (
        output ibus_stb_i, ibus_addr_i,
        input  ibus_rsp_data_o, ibus_rsp_ack_o, ibus_rsp_err_o,
        output dbus_stb_i, dbus_rw_i, dbus_addr_i, dbus_ben_i, dbus_data_i,
        input  dbus_rsp_data_o, dbus_rsp_ack_o, dbus_rsp_err_o,
        input  core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out,
        output core_data_in, core_ack
    );
endinterface

// File: rtl/neorv32_wb_bridge.sv
// Merges the NEORV32 instruction and data request ports onto one Wishbone-classic bus,
// round-robin arbitrated, one cycle at a time, with an ack-timeout that answers with err.
module neorv32_wb_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    neorv32_wb_bridge_if.slave        io_bus
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;

    logic        r_iPend;
    logic [31:0] r_iAddr;
    logic        r_dPend;
    logic        r_dRw;
    logic [31:0] r_dAddr;
    logic [3:0]  r_dBen;
    logic [31:0] r_dData;

    // Last-granted port; also identifies the owner of the active cycle while in S_BUS.
    logic        r_lastGrantD;
    logic [31:0] r_cnt;

    logic        r_we;
    logic [3:0]  r_wstrb;
    logic [31:0] r_addr;
    logic [31:0] r_dataOut;

    logic        r_iAck;
    logic        r_iErr;
    logic [31:0] r_iRspData;
    logic        r_dAck;
    logic        r_dErr;
    logic [31:0] r_dRspData;

    logic        w_iCap;
    logic        w_dCap;
    logic        w_iReq;
    logic        w_dReq;
    logic [31:0] w_iAddr;
    logic        w_dRw;
    logic [31:0] w_dAddr;
    logic [3:0]  w_dBen;
    logic [31:0] w_dData;
    logic        w_timeoutHit;
    logic        w_grant;
    logic        w_grantD;
    logic        w_done;
    logic        w_timeout;
    logic        w_finish;

    assign w_iCap = io_bus.ibus_stb_i & ~r_iPend;
    assign w_dCap = io_bus.dbus_stb_i & ~r_dPend;
    assign w_iReq = r_iPend | w_iCap;
    assign w_dReq = r_dPend | w_dCap;

    // A strobe arriving while idle is granted on the same edge, so bypass the latches.
    assign w_iAddr = r_iPend ? r_iAddr : io_bus.ibus_addr_i;
    assign w_dRw   = r_dPend ? r_dRw   : io_bus.dbus_rw_i;
    assign w_dAddr = r_dPend ? r_dAddr : io_bus.dbus_addr_i;
    assign w_dBen  = r_dPend ? r_dBen  : io_bus.dbus_ben_i;
    assign w_dData = r_dPend ? r_dData : io_bus.dbus_data_i;

    assign w_timeoutHit = (TIMEOUT_CYCLES != 0) && (r_cnt == 32'(TIMEOUT_CYCLES));
    assign w_finish     = w_done | w_timeout;

    always_comb begin
        w_stateNext = r_state;
        w_grant     = 1'b0;
        w_grantD    = r_lastGrantD;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_iReq || w_dReq) begin
                    w_grant     = 1'b1;
                    w_grantD    = (w_iReq && w_dReq) ? ~r_lastGrantD : w_dReq;
                    w_stateNext = S_BUS;
                end
            end
            S_BUS: begin
                if (io_bus.core_ack) begin
                    w_done      = 1'b1;
                    w_stateNext = S_IDLE;
                end else if (w_timeoutHit) begin
                    w_timeout   = 1'b1;
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iPend      <= 1'b0;
            r_iAddr      <= '0;
            r_dPend      <= 1'b0;
            r_dRw        <= 1'b0;
            r_dAddr      <= '0;
            r_dBen       <= '0;
            r_dData      <= '0;
            r_lastGrantD <= 1'b1;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_wstrb      <= '0;
            r_addr       <= '0;
            r_dataOut    <= '0;
            r_iAck       <= 1'b0;
            r_iErr       <= 1'b0;
            r_iRspData   <= '0;
            r_dAck       <= 1'b0;
            r_dErr       <= 1'b0;
            r_dRspData   <= '0;
        end else begin
            r_iAck <= 1'b0;
            r_iErr <= 1'b0;
            r_dAck <= 1'b0;
            r_dErr <= 1'b0;

            if (w_iCap) begin
                r_iPend <= 1'b1;
                r_iAddr <= io_bus.ibus_addr_i;
            end else if (w_finish && !r_lastGrantD) begin
                r_iPend <= 1'b0;
            end

            if (w_dCap) begin
                r_dPend <= 1'b1;
                r_dRw   <= io_bus.dbus_rw_i;
                r_dAddr <= io_bus.dbus_addr_i;
                r_dBen  <= io_bus.dbus_ben_i;
                r_dData <= io_bus.dbus_data_i;
            end else if (w_finish && r_lastGrantD) begin
                r_dPend <= 1'b0;
            end

            if (w_grant) begin
                r_lastGrantD <= w_grantD;
                r_cnt        <= '0;
                r_addr       <= w_grantD ? w_dAddr : w_iAddr;
                r_we         <= w_grantD & w_dRw;
                r_wstrb      <= (w_grantD && w_dRw) ? w_dBen : 4'b0000;
                r_dataOut    <= w_grantD ? w_dData : 32'h0;
            end else if (r_state == S_BUS && !w_finish) begin
                r_cnt <= r_cnt + 32'd1;
            end

            // Write acks leave the read-data register untouched.
            if (w_done) begin
                if (r_lastGrantD) begin
                    r_dAck <= 1'b1;
                    if (!r_we) begin
                        r_dRspData <= io_bus.core_data_in;
                    end
                end else begin
                    r_iAck     <= 1'b1;
                    r_iRspData <= io_bus.core_data_in;
                end
            end else if (w_timeout) begin
                if (r_lastGrantD) begin
                    r_dErr     <= 1'b1;
                    r_dRspData <= '0;
                end else begin
                    r_iErr     <= 1'b1;
                    r_iRspData <= '0;
                end
            end
        end
    end

    assign io_bus.core_cyc        = (r_state == S_BUS);
    assign io_bus.core_stb        = (r_state == S_BUS);
    assign io_bus.core_we         = r_we;
    assign io_bus.core_wstrb      = r_wstrb;
    assign io_bus.core_addr       = r_addr;
    assign io_bus.core_data_out   = r_dataOut;

    assign io_bus.ibus_rsp_ack_o  = r_iAck;
    assign io_bus.ibus_rsp_err_o  = r_iErr;
    assign io_bus.ibus_rsp_data_o = r_iRspData;
    assign io_bus.dbus_rsp_ack_o  = r_dAck;
    assign io_bus.dbus_rsp_err_o  = r_dErr;
    assign io_bus.dbus_rsp_data_o = r_dRspData;
endmodule

// File: doc/neorv32_wb_bridge.md
# neorv32_wb_bridge

Bridges the NEORV32 CPU's separate instruction and data bus request/response ports onto the single Wishbone-classic core bus that the Controller serves in the single-memory configuration. It captures single-cycle CPU request strobes and arbitrates round-robin between the two ports. It runs one Wishbone cycle at a time, returns a one-cycle ack or err response to the originating port, and terminates stalled cycles with a bus-error timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles a Wishbone cycle may wait for ack before being aborted with err; 0 disables the timeout.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- ibus_stb_i  in  1  instruction request strobe, single-cycle pulse.
- ibus_addr_i  in  32  instruction address, stable with strobe.
- ibus_rsp_data_o  out  32  instruction read data.
- ibus_rsp_ack_o  out  1  instruction response ack pulse.
- ibus_rsp_err_o  out  1  instruction response error pulse.
- dbus_stb_i  in  1  data request strobe, single-cycle pulse.
- dbus_rw_i  in  1  1 = write, 0 = read.
- dbus_addr_i  in  32  data address.
- dbus_ben_i  in  4  byte enables.
- dbus_data_i  in  32  write data.
- dbus_rsp_data_o  out  32  data read data.
- dbus_rsp_ack_o  out  1  data response ack pulse.
- dbus_rsp_err_o  out  1  data response error pulse.
- core_cyc  out  1  Wishbone cycle.
- core_stb  out  1  Wishbone strobe; always equal to core_cyc.
- core_we  out  1  Wishbone write enable.
- core_wstrb  out  4  byte strobes.
- core_addr  out  32  address.
- core_data_out  out  32  write data.
- core_data_in  in  32  read data.
- core_ack  in  1  Wishbone acknowledge.

## Operation
- Capture: on a port's stb pulse while that port has no pending or active request, latch the request fields and set the port's pending flag.
  - ibus requests are always reads with ben 4'b1111.
  - A stb on a port that already has a pending or active request is ignored; latched fields are not overwritten.
- States: IDLE and BUS.
- IDLE transitions:
  - If exactly one port is pending, grant it.
  - If both are pending, grant the port not granted last. The last-grant register resets to "dbus", so ibus wins the first tie.
  - On grant, load the core_* outputs from the latched fields and go to BUS.
- BUS signal values:
  - core_cyc = core_stb = 1.
  - core_we = latched rw.
  - core_wstrb = latched ben on writes, 4'b0000 on reads.
  - core_addr is passed unmodified.
  - All core_* outputs are held stable for the whole cycle.
- BUS, core_ack sampled high:
  - Drop cyc/stb.
  - Pulse the granted port's rsp_ack_o for one cycle.
  - On reads, register core_data_in into that port's rsp_data_o.
  - Clear the port's pending flag and return to IDLE.
- BUS, timeout: the timeout counter resets to 0 on entry and increments each cycle without ack. When it reaches TIMEOUT_CYCLES (nonzero):
  - Drop cyc/stb.
  - Pulse rsp_err_o and set rsp_data_o to 0.
  - Clear the port's pending flag and return to IDLE.
  - If ack and timeout coincide, ack wins.
- Read data: rsp_data_o holds its value until that port's next response. A write ack leaves rsp_data_o unchanged.
- Simultaneous events:
  - A stb on the idle port while the other is in BUS is latched and served after the current cycle.
  - A stb on the granted port in the same cycle as its response is ignored.
- Reset state:
  - All outputs 0 and pending flags cleared.
  - State IDLE, last-grant = dbus, counter 0.
  - Reset in the middle of a cycle drops core_cyc on the next edge and discards pending requests without any response.

## Timing
- Request to Wishbone: stb in cycle T → core_cyc high at T+1, provided the bridge is in IDLE and the port wins arbitration.
- Wishbone to response: core_ack sampled in cycle A → rsp_ack_o high and core_cyc low in cycle A+1.
- Minimum load-to-response latency (ack in the same cycle core_cyc rises): stb at T → rsp_ack at T+2.
- Back-to-back transactions are separated by at least one IDLE cycle with core_cyc low.
- Response pulses are exactly one cycle. ack and err are never high together, and never high on both ports in the same cycle.
- Timeout: with no ack, err is pulsed TIMEOUT_CYCLES+1 cycles after core_cyc rises.

## Test plan
- ibus read, addr 0x00000010, slave acks 1 cycle after cyc with 0xDEADBEEF → core_we=0, wstrb=0000; ibus_rsp_ack pulses once with data 0xDEADBEEF; dbus outputs stay idle.
- dbus write, addr 0x00000104, ben 0011, data 0x12345678, immediate ack → core_we=1, wstrb=0011, data_out=0x12345678; dbus_rsp_ack pulses once; dbus_rsp_data unchanged.
- ibus and dbus stb in the same cycle after reset → ibus served first, then dbus after one IDLE cycle. Repeat the collision → dbus served first.
- dbus stb arrives while an ibus cycle is stalled 5 cycles → dbus is captured and issued after the ibus response, with its fields intact.
- TIMEOUT_CYCLES=8, slave never acks → core_cyc drops, and the port's rsp_err pulses 9 cycles after cyc rose with rsp_data=0. Repeat with ack arriving on the timeout cycle → ack response, no err.
- rst asserted during an active stalled cycle with the other port pending → core_cyc low next cycle, no response pulses, and a fresh stb after reset is served normally.
